// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson (twisted-ring) counter with up/down stepping, parallel load,
// illegal-code self-correction, phase decode and terminal-count strobe.
module johnson_counter_gen #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2*WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               clr_err,
    output logic [WIDTH-1:0]   q,
    output logic [PW-1:0]      phase,
    output logic [2*WIDTH-1:0] phase_oh,
    output logic               tc,
    output logic               err
);

    logic             legal;
    logic [WIDTH-1:0] q_step;

    // Legal pattern for phase p: p ones from the MSB (p <= WIDTH),
    // otherwise (p - WIDTH) zeros from the MSB with ones below.
    function automatic logic [WIDTH-1:0] code_of(input int unsigned p);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (p <= WIDTH) c[WIDTH-1-i] = (i < p);
            else            c[WIDTH-1-i] = (i >= p - WIDTH);
        end
        return c;
    endfunction

    always_comb begin
        phase    = '0;
        phase_oh = '0;
        legal    = 1'b0;
        for (int unsigned p = 0; p < 2*WIDTH; p++) begin
            if (q == code_of(p)) begin
                phase       = PW'(p);
                phase_oh[p] = 1'b1;
                legal       = 1'b1;
            end
        end
    end

    always_comb begin
        if (dir) q_step = {q[WIDTH-2:0], ~q[WIDTH-1]};
        else     q_step = {~q[0], q[WIDTH-1:1]};
    end

    assign tc = en & ~load & ~reset & legal &
                (dir ? phase_oh[0] : phase_oh[2*WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= '0;
            err <= 1'b0;
        end else begin
            if (load)       q <= load_val;
            else if (!legal) q <= '0;
            else if (en)    q <= q_step;

            // A load pre-empts correction, so err only sets when no load is present.
            if (!load && !legal) err <= 1'b1;
            else if (clr_err)    err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_johnson_counter_gen.sv
// Scoreboard bench for johnson_counter_gen at WIDTH=4 and WIDTH=6, driven in lockstep.
module tb_johnson_counter_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, dir, load, clr_err;
    logic [3:0]  lv4;
    logic [5:0]  lv6;

    logic [3:0]  q4;
    logic [2:0]  ph4;
    logic [7:0]  oh4;
    logic        tc4, err4;
    logic [5:0]  q6;
    logic [3:0]  ph6;
    logic [11:0] oh6;
    logic        tc6, err6;

    johnson_counter_gen #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv4),
        .clr_err(clr_err), .q(q4), .phase(ph4), .phase_oh(oh4), .tc(tc4), .err(err4)
    );

    johnson_counter_gen #(.WIDTH(6)) dut6 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv6),
        .clr_err(clr_err), .q(q6), .phase(ph6), .phase_oh(oh6), .tc(tc6), .err(err6)
    );

    typedef struct {
        int q;
        int ph;
        int oh;
        int err;
        int tc;
    } exp_t;

    exp_t sb4[$];
    exp_t sb6[$];

    int passed = 0;
    int total  = 0;
    int mq[2];
    int merr[2];

    // Legal code for phase p of a w-bit ring, built arithmetically.
    function automatic int code(input int w, input int p);
        if (p <= w) return ((1 << p) - 1) << (w - p);
        return (1 << (2*w - p)) - 1;
    endfunction

    function automatic int phase_of(input int w, input int v);
        for (int p = 0; p < 2*w; p++)
            if (code(w, p) == v) return p;
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    endtask

    // Drive one cycle of stimulus and push the post-edge expectation for each DUT.
    task automatic cyc(input bit r, input bit e, input bit d, input bit ld,
                       input int lv4v, input int lv6v, input bit c);
        exp_t x;
        int   w, lv, ph, np, nq, ne;
        reset   = r;
        en      = e;
        dir     = d;
        load    = ld;
        lv4     = lv4v[3:0];
        lv6     = lv6v[5:0];
        clr_err = c;
        for (int i = 0; i < 2; i++) begin
            w  = (i == 0) ? 4 : 6;
            lv = (i == 0) ? (lv4v & 15) : (lv6v & 63);
            ph = phase_of(w, mq[i]);
            nq = mq[i];
            ne = merr[i];
            if (r) begin
                nq = 0;
                ne = 0;
            end else begin
                if (ld)          nq = lv;
                else if (ph < 0) nq = 0;
                else if (e)      nq = code(w, d ? (ph + 2*w - 1) % (2*w) : (ph + 1) % (2*w));
                if (!ld && ph < 0) ne = 1;
                else if (c)        ne = 0;
            end
            mq[i]   = nq;
            merr[i] = ne;
            np      = phase_of(w, nq);
            x.q     = nq;
            x.ph    = (np < 0) ? 0 : np;
            x.oh    = (np < 0) ? 0 : (1 << np);
            x.err   = ne;
            x.tc    = (e && !ld && !r && np >= 0 && (d ? np == 0 : np == 2*w - 1)) ? 1 : 0;
            if (i == 0) sb4.push_back(x);
            else        sb6.push_back(x);
        end
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb4.size() > 0) begin
                x = sb4.pop_front();
                chk("w4_q",     int'(q4),   x.q);
                chk("w4_phase", int'(ph4),  x.ph);
                chk("w4_oh",    int'(oh4),  x.oh);
                chk("w4_err",   int'(err4), x.err);
                chk("w4_tc",    int'(tc4),  x.tc);
            end
            if (sb6.size() > 0) begin
                x = sb6.pop_front();
                chk("w6_q",     int'(q6),   x.q);
                chk("w6_phase", int'(ph6),  x.ph);
                chk("w6_oh",    int'(oh6),  x.oh);
                chk("w6_err",   int'(err6), x.err);
                chk("w6_tc",    int'(tc6),  x.tc);
            end
        end
    end

    initial begin : stimulus
        mq   = '{0, 0};
        merr = '{0, 0};

        // Forward run through a full wrap
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 0, 0, 0);

        // Reverse from reset, then a single forward step
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // Enable gating
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // Illegal load, correction with en low, then clear
        cyc(0, 0, 0, 1, 'b1010, 'b101010, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Legal load beats a simultaneous enable
        cyc(0, 1, 0, 1, 'b0111, 'b011111, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // Reset beats load and en mid-run, then a full forward lap
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 'b1010, 'b101101, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
                ($urandom_range(0, 7) == 0));
        end

        reset   = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        clr_err = 1'b0;
        @(negedge clk);
        chk("sb_drained", sb4.size() + sb6.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
